aib_rx_chnl_aligner: RTL

Multi-channel receive-side deskew block for the AXI-over-AIB bridge. It is the parametrised successor to the single-channel follower datapath. It accepts NBR_CHNLS per-channel AIB receive words, each arriving with independent skew, and locks onto a per-word alignment marker bit. It then emits one channel-aligned wide word per cycle to the AXI-MM leader/follower core. It sits between the AIB channel `data_out` buses and the AXI-MM `rx_phy*` inputs, in the `clk_wr` domain.

---
 rtl/aib_rx_chnl_aligner_if.sv | 22 ++
 rtl/aib_rx_chnl_aligner.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/aib_rx_chnl_aligner_if.sv
`default_nettype none
// ============================================================================
//  Module   : aib_rx_chnl_aligner_if
//  Purpose  : Valid-qualified data bus between the AIB receive channels, the
//             channel aligner and the AXI-MM rx_phy inputs.
//  Signals  : data - packed channel words, channel c at [c*W +: W]
//             vld  - word valid (per channel on the PHY side, single bit on
//                    the aligned side)
//  Modports : master drives data/vld, slave samples them.
//  Revision : 1.0 - initial release
// ============================================================================
interface aib_rx_chnl_aligner_if #(
    parameter int DATA_W = 320,
    parameter int VLD_W  = 4
);
    logic [DATA_W-1:0] data;
    logic [VLD_W-1:0]  vld;

    modport master (output data, output vld);
    modport slave  (input  data, input  vld);
endinterface
`default_nettype wire

// File: rtl/aib_rx_chnl_aligner.sv
`default_nettype none
// ============================================================================
//  Module   : aib_rx_chnl_aligner
//  Purpose  : Multi-channel AIB receive deskew. Each channel hunts for a word
//             with MARKER_BIT set, buffers from that word onwards in its own
//             FIFO, and once every channel has found its marker the heads of
//             all FIFOs are popped together as one aligned wide word.
//  Ports    : clk_wr, rst_wr      - clock, synchronous active-high reset
//             rx_online           - all channels ready; low forces IDLE
//             align_en            - level request for alignment
//             rx_phy (slave)      - per-channel words + per-channel valids
//             rx_aligned (master) - aligned wide word + single valid
//             align_done          - high while LOCKED
//             align_err           - high while in ERROR
//             fifo_ovf            - sticky per-channel overflow flags
//  Options  : ALIGN_MARKER_CHECK_EN - when defined, every popped group in
//             LOCKED must agree on MARKER_BIT across channels, else ERROR.
//  Revision : 1.0 - initial release
// ============================================================================
module aib_rx_chnl_aligner #(
    parameter int NBR_CHNLS     = 4,
    parameter int DWIDTH        = 80,
    parameter int FIFO_DEPTH    = 8,
    parameter int MARKER_BIT    = 79,
    parameter int ALIGN_TIMEOUT = 32
) (
    input  wire logic                 clk_wr,
    input  wire logic                 rst_wr,
    input  wire logic                 rx_online,
    input  wire logic                 align_en,
    aib_rx_chnl_aligner_if.slave      rx_phy,
    aib_rx_chnl_aligner_if.master     rx_aligned,
    output logic                      align_done,
    output logic                      align_err,
    output logic [NBR_CHNLS-1:0]      fifo_ovf
);

    localparam int c_PW = $clog2(FIFO_DEPTH);
    localparam int c_CW = $clog2(FIFO_DEPTH + 1);
    localparam int c_TW = $clog2(ALIGN_TIMEOUT + 1);
    localparam logic [c_CW-1:0] c_FULL = c_CW'(FIFO_DEPTH);
    localparam logic [c_TW-1:0] c_TMO  = c_TW'(ALIGN_TIMEOUT);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_HUNT   = 2'd1;
    localparam logic [1:0] c_ST_LOCKED = 2'd2;
    localparam logic [1:0] c_ST_ERROR  = 2'd3;

    logic [1:0]                  r_state;
    logic [1:0]                  w_state_nxt;
    logic [NBR_CHNLS-1:0]        r_found;
    logic [NBR_CHNLS-1:0]        w_found_nxt;
    logic [c_TW-1:0]             r_tmo_cnt;
    logic [NBR_CHNLS*DWIDTH-1:0] r_out_data;
    logic [NBR_CHNLS*DWIDTH-1:0] w_heads;
    logic                        r_out_vld;
    logic                        r_align_done;
    logic                        r_align_err;
    logic [NBR_CHNLS-1:0]        r_fifo_ovf;

    logic [NBR_CHNLS-1:0]        w_in_mk;
    logic [NBR_CHNLS-1:0]        w_nempty;
    logic [NBR_CHNLS-1:0]        w_full;
    logic [NBR_CHNLS-1:0]        w_wr_req;
    logic [NBR_CHNLS-1:0]        w_ovf;
    logic [NBR_CHNLS-1:0]        w_wr;
    logic                        w_hunt;
    logic                        w_locked;
    logic                        w_active;
    logic                        w_pop;
    logic                        w_mk_mix;

    assign w_hunt   = (r_state == c_ST_HUNT);
    assign w_locked = (r_state == c_ST_LOCKED);
    // FIFOs only hold data in HUNT/LOCKED; IDLE and ERROR keep them flushed.
    assign w_active = w_hunt || w_locked;

    // Pop is suppressed when the link is about to drop back to IDLE so that
    // no valid word is presented alongside the IDLE state.
    assign w_pop = w_locked && rx_online && align_en && (&w_nempty);

    assign w_found_nxt = r_found | (rx_phy.vld & w_in_mk);

`ifdef ALIGN_MARKER_CHECK_EN
    logic [NBR_CHNLS-1:0] w_head_mk;
    assign w_mk_mix = (|w_head_mk) && !(&w_head_mk);
`else
    assign w_mk_mix = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Per-channel deskew FIFO
    // ------------------------------------------------------------------------
    for (genvar c = 0; c < NBR_CHNLS; c++) begin : g_chnl
        logic [DWIDTH-1:0] r_mem [FIFO_DEPTH];
        logic [c_PW-1:0]   r_wr_ptr;
        logic [c_PW-1:0]   r_rd_ptr;
        logic [c_CW-1:0]   r_count;
        logic [DWIDTH-1:0] w_in;

        assign w_in       = rx_phy.data[c*DWIDTH +: DWIDTH];
        assign w_in_mk[c] = w_in[MARKER_BIT];
        assign w_heads[c*DWIDTH +: DWIDTH] = r_mem[r_rd_ptr];
        assign w_nempty[c] = (r_count != '0);
        assign w_full[c]   = (r_count == c_FULL);

        // Until its marker is seen a channel drops unmarked words.
        assign w_wr_req[c] = w_active && rx_phy.vld[c] &&
                             (w_locked || r_found[c] || w_in_mk[c]);
        // A full FIFO can still accept a word when the same cycle pops.
        assign w_ovf[c] = w_wr_req[c] && w_full[c] && !w_pop;
        assign w_wr[c]  = w_wr_req[c] && !w_ovf[c];

`ifdef ALIGN_MARKER_CHECK_EN
        assign w_head_mk[c] = r_mem[r_rd_ptr][MARKER_BIT];
`endif

        always_ff @(posedge clk_wr) begin
            if (w_wr[c]) begin
                r_mem[r_wr_ptr] <= w_in;
            end
        end

        always_ff @(posedge clk_wr) begin
            if (rst_wr || !w_active) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_wr[c]) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_wr[c], w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state decode; link loss and align_en release take priority.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (!rx_online) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (align_en) begin
                        w_state_nxt = c_ST_HUNT;
                    end
                end
                c_ST_HUNT: begin
                    if (!align_en) begin
                        w_state_nxt = c_ST_IDLE;
                    end else if (|w_ovf) begin
                        w_state_nxt = c_ST_ERROR;
                    end else if (&w_found_nxt) begin
                        w_state_nxt = c_ST_LOCKED;
                    end else if (r_tmo_cnt == c_TMO) begin
                        w_state_nxt = c_ST_ERROR;
                    end
                end
                c_ST_LOCKED: begin
                    if (!align_en) begin
                        w_state_nxt = c_ST_IDLE;
                    end else if ((|w_ovf) || (w_pop && w_mk_mix)) begin
                        w_state_nxt = c_ST_ERROR;
                    end
                end
                default: begin
                    if (!align_en) begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State, hunt bookkeeping and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            r_state      <= c_ST_IDLE;
            r_found      <= '0;
            r_tmo_cnt    <= '0;
            r_out_data   <= '0;
            r_out_vld    <= 1'b0;
            r_align_done <= 1'b0;
            r_align_err  <= 1'b0;
            r_fifo_ovf   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_found <= w_hunt ? w_found_nxt : '0;
            // Timeout window opens on the cycle the first marker lands.
            r_tmo_cnt <= (w_hunt && (r_found != '0)) ? r_tmo_cnt + 1'b1 : '0;

            if (w_pop) begin
                r_out_data <= w_heads;
                r_out_vld  <= 1'b1;
            end else begin
                r_out_vld  <= 1'b0;
            end

            r_align_done <= (w_state_nxt == c_ST_LOCKED);
            r_align_err  <= (w_state_nxt == c_ST_ERROR);

            // Overflow history survives IDLE so software can inspect it; it
            // is only discarded when a fresh hunt starts.
            if ((r_state == c_ST_IDLE) && (w_state_nxt == c_ST_HUNT)) begin
                r_fifo_ovf <= '0;
            end else begin
                r_fifo_ovf <= r_fifo_ovf | w_ovf;
            end
        end
    end

    assign rx_aligned.data = r_out_data;
    assign rx_aligned.vld  = r_out_vld;
    assign align_done      = r_align_done;
    assign align_err       = r_align_err;
    assign fifo_ovf        = r_fifo_ovf;

endmodule
`default_nettype wire
